// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic pipeline-stage register:
// FSM state encoding, default widths and occupancy decode.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b10
  } pipe_state_e;

  localparam int unsigned DEF_CTRL_W = 8;
  localparam int unsigned DEF_DATA_W = 128;
  localparam int unsigned DEF_CNT_W  = 16;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_FULL  = 2'd1;
  localparam logic [1:0] OCC_SKID  = 2'd2;

  function automatic logic [1:0] occ_of(input pipe_state_e s);
    case (s)
      FULL:    occ_of = OCC_FULL;
      SKID:    occ_of = OCC_SKID;
      default: occ_of = OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle of one pipeline stage: upstream side (valid_i/ready_o/ctrl_i/data_i)
// and downstream side (valid_o/ready_i/ctrl_o/data_o) plus occupancy.
interface pipe_stage_skid_if
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic              valid_i;
  logic              ready_o;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_o;
  logic              ready_i;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] data_o;
  logic [1:0]        occupancy_o;

  modport master (
    output valid_i, ctrl_i, data_i, ready_i,
    input  ready_o, valid_o, ctrl_o, data_o, occupancy_o
  );

  modport slave (
    input  valid_i, ctrl_i, data_i, ready_i,
    output ready_o, valid_o, ctrl_o, data_o, occupancy_o
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with a variable increment; sticks at all-ones until reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned INC_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [INC_W-1:0] inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W:0] sum;

  assign sum = {1'b0, cnt_o} + (CNT_W+1)'(inc_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)          cnt_o <= '0;
    else if (sum[CNT_W]) cnt_o <= '1;
    else                 cnt_o <= sum[CNT_W-1:0];
  end
endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with a 2-entry skid buffer, flush and start gating.
// Optional macro PIPE_STATS_EN adds saturating stall/drop statistics counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W      = DEF_CTRL_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter bit          BUBBLE_ZERO = 1'b1,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  pipe_stage_skid_if.slave bus
`ifdef PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
`endif
);
  pipe_state_e       state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic              valid_q, ready_q;
  logic [1:0]        occ_q;
  logic              in_fire, out_fire, clear;

  assign in_fire  = bus.valid_i & ready_q;
  assign out_fire = valid_q & bus.ready_i;
  assign clear    = ~start_i | flush_i;

  assign bus.ready_o     = ready_q;
  assign bus.valid_o     = valid_q;
  assign bus.ctrl_o      = main_ctrl_q;
  assign bus.data_o      = main_data_q;
  assign bus.occupancy_o = occ_q;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (in_fire) state_d = FULL;
        FULL: begin
          if (in_fire && !out_fire)      state_d = SKID;
          else if (!in_fire && out_fire) state_d = EMPTY;
        end
        SKID:    if (out_fire) state_d = FULL;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake flags are registered from the next state so ready_o never sees ready_i.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= EMPTY;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
      occ_q       <= OCC_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != EMPTY);
      ready_q <= (state_d != SKID);
      occ_q   <= occ_of(state_d);
      if (clear) begin
        main_ctrl_q <= '0;
        skid_ctrl_q <= '0;
        if (BUBBLE_ZERO) begin
          main_data_q <= '0;
          skid_data_q <= '0;
        end
      end else begin
        case (state_q)
          EMPTY: begin
            if (in_fire) begin
              main_ctrl_q <= bus.ctrl_i;
              main_data_q <= bus.data_i;
            end
          end
          FULL: begin
            if (in_fire && out_fire) begin
              main_ctrl_q <= bus.ctrl_i;
              main_data_q <= bus.data_i;
            end else if (in_fire) begin
              skid_ctrl_q <= bus.ctrl_i;
              skid_data_q <= bus.data_i;
            end else if (out_fire) begin
              main_ctrl_q <= '0;
              if (BUBBLE_ZERO) main_data_q <= '0;
            end
          end
          SKID: begin
            if (out_fire) begin
              main_ctrl_q <= skid_ctrl_q;
              main_data_q <= skid_data_q;
              skid_ctrl_q <= '0;
              skid_data_q <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PIPE_STATS_EN
  logic [1:0] stall_inc, drop_inc;

  assign stall_inc = {1'b0, valid_q & ~bus.ready_i};
  assign drop_inc  = clear ? occ_q : 2'd0;

  sat_counter #(.CNT_W(CNT_W), .INC_W(2)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W), .INC_W(2)) u_drop_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (drop_inc),
    .cnt_o (drop_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: vector table, hand sequences and random traffic against
// a queue-based reference model; two instances cover BUBBLE_ZERO=1 and BUBBLE_ZERO=0.
module tb_pipe_stage_skid;
  localparam int unsigned CW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 4;
  localparam int unsigned CNT_MAX = (1 << NW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic start, flush;
  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) bus1 ();
  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) bus0 ();

`ifdef PIPE_STATS_EN
  logic [NW-1:0] stall1, drop1, stall0, drop0;
`endif

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .BUBBLE_ZERO(1'b1), .CNT_W(NW)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .flush_i(flush), .bus(bus1)
`ifdef PIPE_STATS_EN
    , .stall_cnt_o(stall1), .drop_cnt_o(drop1)
`endif
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .BUBBLE_ZERO(1'b0), .CNT_W(NW)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .flush_i(flush), .bus(bus0)
`ifdef PIPE_STATS_EN
    , .stall_cnt_o(stall0), .drop_cnt_o(drop0)
`endif
  );

  // Reference model: a FIFO of at most two entries.
  typedef struct packed { logic [CW-1:0] c; logic [DW-1:0] d; } ent_t;
  ent_t          mq[$];
  logic [DW-1:0] last0;
  int unsigned   stall_m, drop_m;

  typedef struct packed {
    logic v; logic [CW-1:0] c; logic [DW-1:0] d; logic r; logic s; logic f;
    logic ev; logic er; logic [1:0] eo; logic [CW-1:0] ec; logic [DW-1:0] ed;
  } vec_t;
  vec_t tbl [20];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int unsigned sat(input int unsigned x);
    return (x > CNT_MAX) ? CNT_MAX : x;
  endfunction

  task automatic model_reset();
    mq.delete();
    last0   = '0;
    stall_m = 0;
    drop_m  = 0;
  endtask

  task automatic model_step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                            input logic r, input logic s, input logic f);
    int unsigned n = mq.size();
    bit inf  = v && (n < 2);
    bit outf = (n > 0) && r;
    if (n > 0 && !r) stall_m = sat(stall_m + 1);
    if (!s || f) begin
      drop_m = sat(drop_m + n);
      mq.delete();
    end else begin
      if (outf) void'(mq.pop_front());
      if (inf) mq.push_back('{c: c, d: d});
    end
    if (mq.size() > 0) last0 = mq[0].d;
  endtask

  task automatic check_model();
    int unsigned n = mq.size();
    logic [CW-1:0] ec = (n > 0) ? mq[0].c : '0;
    logic [DW-1:0] e1 = (n > 0) ? mq[0].d : '0;
    chk("valid_bz1", 64'(bus1.valid_o), 64'(n > 0));
    chk("ready_bz1", 64'(bus1.ready_o), 64'(n < 2));
    chk("occ_bz1",   64'(bus1.occupancy_o), 64'(n));
    chk("ctrl_bz1",  64'(bus1.ctrl_o), 64'(ec));
    chk("data_bz1",  64'(bus1.data_o), 64'(e1));
    chk("valid_bz0", 64'(bus0.valid_o), 64'(n > 0));
    chk("occ_bz0",   64'(bus0.occupancy_o), 64'(n));
    chk("ctrl_bz0",  64'(bus0.ctrl_o), 64'(ec));
    chk("data_bz0",  64'(bus0.data_o), 64'(last0));
`ifdef PIPE_STATS_EN
    chk("stall_cnt", 64'(stall1), 64'(stall_m));
    chk("drop_cnt",  64'(drop1),  64'(drop_m));
    chk("stall_cnt_bz0", 64'(stall0), 64'(stall_m));
`endif
  endtask

  // Called at a falling edge: apply inputs, advance the model, check after the next edge.
  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic r, input logic s, input logic f);
    bus1.valid_i = v; bus1.ctrl_i = c; bus1.data_i = d; bus1.ready_i = r;
    bus0.valid_i = v; bus0.ctrl_i = c; bus0.data_i = d; bus0.ready_i = r;
    start = s; flush = f;
    model_step(v, c, d, r, s, f);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_inputs();
    bus1.valid_i = 1'b0; bus1.ctrl_i = '0; bus1.data_i = '0; bus1.ready_i = 1'b1;
    bus0.valid_i = 1'b0; bus0.ctrl_i = '0; bus0.data_i = '0; bus0.ready_i = 1'b1;
    start = 1'b1; flush = 1'b0;
  endtask

  initial begin
    //           v   c      d             r s f   ev er eo  ec     ed
    tbl[0]  = '{1, 8'h01, 32'h1,        1,1,0,  1, 1, 1, 8'h01, 32'h1};
    tbl[1]  = '{1, 8'h02, 32'h2,        1,1,0,  1, 1, 1, 8'h02, 32'h2};
    tbl[2]  = '{1, 8'h03, 32'h3,        1,1,0,  1, 1, 1, 8'h03, 32'h3};
    tbl[3]  = '{0, 8'h00, 32'h0,        1,1,0,  0, 1, 0, 8'h00, 32'h0};
    tbl[4]  = '{1, 8'h0A, 32'hA,        0,1,0,  1, 1, 1, 8'h0A, 32'hA};
    tbl[5]  = '{1, 8'h0B, 32'hB,        0,1,0,  1, 0, 2, 8'h0A, 32'hA};
    tbl[6]  = '{1, 8'h0C, 32'hC,        0,1,0,  1, 0, 2, 8'h0A, 32'hA};
    tbl[7]  = '{0, 8'h00, 32'h0,        1,1,0,  1, 1, 1, 8'h0B, 32'hB};
    tbl[8]  = '{0, 8'h00, 32'h0,        1,1,0,  0, 1, 0, 8'h00, 32'h0};
    tbl[9]  = '{1, 8'h11, 32'h11,       0,1,0,  1, 1, 1, 8'h11, 32'h11};
    tbl[10] = '{1, 8'h22, 32'h22,       0,1,0,  1, 0, 2, 8'h11, 32'h11};
    tbl[11] = '{1, 8'h33, 32'h33,       0,1,1,  0, 1, 0, 8'h00, 32'h0};
    tbl[12] = '{0, 8'h00, 32'h0,        1,1,0,  0, 1, 0, 8'h00, 32'h0};
    tbl[13] = '{1, 8'hFF, 32'h5,        1,0,0,  0, 1, 0, 8'h00, 32'h0};
    tbl[14] = '{1, 8'hFF, 32'h5,        1,0,0,  0, 1, 0, 8'h00, 32'h0};
    tbl[15] = '{1, 8'hFF, 32'h5,        1,0,0,  0, 1, 0, 8'h00, 32'h0};
    tbl[16] = '{1, 8'h44, 32'h44,       1,1,0,  1, 1, 1, 8'h44, 32'h44};
    tbl[17] = '{0, 8'h00, 32'h0,        1,1,0,  0, 1, 0, 8'h00, 32'h0};
    tbl[18] = '{1, 8'h05, 32'hDEADBEEF, 1,1,0,  1, 1, 1, 8'h05, 32'hDEADBEEF};
    tbl[19] = '{0, 8'h00, 32'h0,        1,1,0,  0, 1, 0, 8'h00, 32'h0};

    idle_inputs();
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_valid", 64'(bus1.valid_o), 64'(0));
    chk("reset_ready", 64'(bus1.ready_o), 64'(1));
    chk("reset_occ",   64'(bus1.occupancy_o), 64'(0));
    chk("reset_ctrl",  64'(bus1.ctrl_o), 64'(0));
    chk("reset_data",  64'(bus1.data_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].c, tbl[i].d, tbl[i].r, tbl[i].s, tbl[i].f);
      chk($sformatf("vec%0d_valid", i), 64'(bus1.valid_o), 64'(tbl[i].ev));
      chk($sformatf("vec%0d_ready", i), 64'(bus1.ready_o), 64'(tbl[i].er));
      chk($sformatf("vec%0d_occ", i),   64'(bus1.occupancy_o), 64'(tbl[i].eo));
      chk($sformatf("vec%0d_ctrl", i),  64'(bus1.ctrl_o), 64'(tbl[i].ec));
      chk($sformatf("vec%0d_data", i),  64'(bus1.data_o), 64'(tbl[i].ed));
`ifdef PIPE_STATS_EN
      if (i == 11) chk("flush_drop_cnt", 64'(drop1), 64'(2));
`endif
    end
    chk("bz0_hold_data", 64'(bus0.data_o), 64'(32'hDEADBEEF));
    chk("bz0_bubble_ctrl", 64'(bus0.ctrl_o), 64'(0));

    // Asynchronous reset between edges while two entries are held.
    drive(1'b1, 8'h61, 32'h61, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'h62, 32'h62, 1'b0, 1'b1, 1'b0);
    chk("pre_reset_occ", 64'(bus1.occupancy_o), 64'(2));
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(bus1.valid_o), 64'(0));
    chk("async_ctrl",  64'(bus1.ctrl_o), 64'(0));
    chk("async_data",  64'(bus1.data_o), 64'(0));
    chk("async_occ",   64'(bus1.occupancy_o), 64'(0));
    chk("async_data_bz0", 64'(bus0.data_o), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Long stall: stall counter reaches its ceiling, head entry stays put.
    drive(1'b1, 8'h77, 32'h77, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < int'(CNT_MAX) + 5; i++)
      drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("stall_head_data", 64'(bus1.data_o), 64'(32'h77));
`ifdef PIPE_STATS_EN
    chk("stall_saturated", 64'(stall1), 64'(CNT_MAX));
`endif
    drive(1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 99) < 70), 8'($urandom), 32'($urandom),
            1'($urandom_range(0, 99) < 65), 1'($urandom_range(0, 99) >= 4),
            1'($urandom_range(0, 99) < 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline-stage register that replaces the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries an opaque control vector and data vector under a valid/ready handshake. A 2-entry skid buffer lets downstream stalls propagate upstream without combinational ready paths. It provides flush and bubble insertion; the start gate forces bubbles.

Parameters:
CTRL_W, 8, width of control field (RegWrite, MemRead, Branch, ...); always zeroed when no valid entry is held
DATA_W, 128, width of data payload (pc, operands, imm, reg addresses)
BUBBLE_ZERO, 1, 1 = data_o zeroed whenever valid_o=0; 0 = data_o holds its last value (power saving)
CNT_W, 16, width of statistics counters (optional feature only)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
start_i  input  1  global run enable; low = synchronous bubble/clear every cycle
flush_i  input  1  synchronous kill of all held entries (branch mispredict / hazard flush)
valid_i  input  1  upstream entry valid
ready_o  output  1  stage can accept; registered-state only, no path from ready_i
ctrl_i  input  CTRL_W  upstream control field
data_i  input  DATA_W  upstream data payload
valid_o  output  1  downstream entry valid
ready_i  input  1  downstream accepts
ctrl_o  output  CTRL_W  control field of head entry
data_o  output  DATA_W  data payload of head entry
occupancy_o  output  2  entries held: 0, 1 or 2

Behaviour:
- in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- States: EMPTY (0 entries), FULL (main entry only), SKID (main and skid entries). Reset state is EMPTY.
- Reset (rst_i=0, asynchronous): state=EMPTY, valid_o=0, ctrl_o=0, data_o=0, occupancy_o=0, skid regs=0. Any transfer while rst_i=0 is discarded.
- ready_o = 1 in EMPTY/FULL, 0 in SKID.
- valid_o = 1 in FULL/SKID.
- occupancy_o = 0/1/2 for EMPTY/FULL/SKID.
- Transitions (priority order):
  1. start_i=0 or flush_i=1: next state EMPTY; main and skid ctrl cleared; data cleared if BUBBLE_ZERO=1. An in_fire in the same cycle is dropped.
  2. EMPTY: in_fire -> FULL, main<=input. Otherwise stay.
  3. FULL: in_fire & out_fire -> FULL, main<=input. in_fire only -> SKID, skid<=input, main held. out_fire only -> EMPTY, main ctrl cleared (data cleared if BUBBLE_ZERO=1). Neither -> hold.
  4. SKID: out_fire -> FULL, main<=skid, skid cleared. Otherwise hold all.
- Latency: 1 cycle from in_fire into EMPTY to valid_o=1.
- Throughput: 1 entry/cycle with ready_i held high. Order is strictly FIFO; no entry is duplicated or lost except on flush/start_i=0.
- While valid_o=1 and ready_i=0, ctrl_o/data_o are stable.
- ctrl_o is 0 whenever valid_o=0, regardless of BUBBLE_ZERO, so bubbles never assert write or memory enables downstream.

Optional Feature:
PIPE_STATS_EN
- Defined: adds outputs stall_cnt_o [CNT_W] and drop_cnt_o [CNT_W].
  - stall_cnt_o increments each cycle with valid_o & ~ready_i.
  - drop_cnt_o adds occupancy (1 or 2) on each flush/start_i=0 cycle that discards held entries.
  - Both saturate at all-ones and clear only on rst_i.
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- Package pipe_pkg:
  - typedef pipe_state_e {EMPTY=2'b00, FULL=2'b01, SKID=2'b10}
  - default width constants (CTRL_W, DATA_W, CNT_W)
  - occupancy encoding
- Sub-module sat_counter (CNT_W width, increment amount input, saturating), instantiated twice under PIPE_STATS_EN. Core state machine stays in one module.

Test Plan:
- Reset then stream: start_i=1, ready_i=1, valid_i=1, data_i=1,2,3 on consecutive cycles -> data_o=1,2,3 one cycle later each; occupancy_o=1 throughout; ready_o stays 1.
- Backpressure: ready_i=0 with entries A,B sent -> occupancy_o=2, ready_o=0, data_o=A stable. Raise ready_i -> A then B out in order, ready_o=1 one cycle after A leaves.
- Flush in SKID with simultaneous valid_i=1 (entry C) -> next cycle valid_o=0, ctrl_o=0, occupancy_o=0; C never appears; drop_cnt_o=2 with PIPE_STATS_EN.
- start_i=0 for 3 cycles with valid_i=1, ctrl_i=8'hFF -> valid_o=0, ctrl_o=0 every cycle. Re-raise start_i -> normal 1-cycle latency resumes.
- BUBBLE_ZERO=0 and =1 runs: send 32'hDEADBEEF, drain -> with 0 data_o holds DEADBEEF, ctrl_o=0; with 1 data_o=0.
- Async reset asserted mid-SKID between clock edges -> valid_o, ctrl_o, data_o, occupancy_o go 0 immediately, without waiting for a clock edge. Stall of 2^CNT_W+5 cycles -> stall_cnt_o saturates at all-ones.
